// File: rtl/jt51_exp_pkg.sv
// Shared constants and elaboration-time helpers for the jt51 log-to-linear path.
// Rounding is enabled with JT51_EXP_ROUND_EN (see jt51_exp2lin).
package jt51_exp_pkg;

    localparam int FRAC_W_DEF  = 8;
    localparam int MANT_W_DEF  = 16;
    localparam int SHIFT_W_DEF = 5;
    localparam int OUT_W_DEF   = 14;

    // Entry idx of the 2^x mantissa table: round(2^mant_w * (2^(1-(idx+1)/2^frac_w) - 1)).
    // Only ever evaluated at elaboration to build constant table words.
    function automatic logic [31:0] exp_entry(input int idx, input int frac_w, input int mant_w);
        real x;
        x = (2.0 ** (1.0 - real'(idx + 1) / (2.0 ** frac_w)) - 1.0) * (2.0 ** mant_w);
        return 32'($rtoi(x + 0.5));
    endfunction

    // Bit position of the magnitude LSB inside the (MANT_W+1)-bit shifted word.
    function automatic int mag_lsb(input int mant_w, input int out_w);
        return mant_w - out_w + 2;
    endfunction

endpackage

// File: rtl/jt51_exp2lin_if.sv
// Sample bus of the log-to-linear converter: attenuation/sign in, signed linear sample out.
interface jt51_exp2lin_if
    import jt51_exp_pkg::*;
#(
    parameter int SHIFT_W = SHIFT_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF,
    parameter int OUT_W   = OUT_W_DEF
);
    logic                        in_valid;
    logic [SHIFT_W+FRAC_W-1:0]   atten;
    logic                        sign;
    logic signed [OUT_W-1:0]     dout;
    logic                        out_valid;

    modport master (output in_valid, atten, sign, input  dout, out_valid);
    modport slave  (input  in_valid, atten, sign, output dout, out_valid);
endinterface

// File: rtl/jt51_exp2lin_rom.sv
// Registered, cen-gated 2^x mantissa table; contents are fixed at elaboration.
module jt51_exp2lin_rom
    import jt51_exp_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int MANT_W = MANT_W_DEF
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic [FRAC_W-1:0] addr,
    output logic [MANT_W-1:0] q
);
    localparam int DEPTH = 1 << FRAC_W;

    logic [MANT_W-1:0] tbl [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_tbl
        localparam logic [MANT_W-1:0] ENTRY = MANT_W'(exp_entry(g, FRAC_W, MANT_W));
        assign tbl[g] = ENTRY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (cen)
            q <= tbl[addr];
    end
endmodule

// File: rtl/jt51_exp2lin.sv
// Log-to-linear converter: S1 table lookup, S2 shift (+ optional round), S3 sign.
// Define JT51_EXP_ROUND_EN to round-to-nearest with saturation in S2.
module jt51_exp2lin
    import jt51_exp_pkg::*;
#(
    parameter int FRAC_W  = FRAC_W_DEF,
    parameter int MANT_W  = MANT_W_DEF,
    parameter int SHIFT_W = SHIFT_W_DEF,
    parameter int OUT_W   = OUT_W_DEF
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cen,
    jt51_exp2lin_if.slave      bus
);
    localparam int STAGES = 3;
    localparam int LSB    = mag_lsb(MANT_W, OUT_W);
    localparam int MAG_W  = OUT_W - 1;

    logic                armed;
    logic [STAGES:1]     vld_pipe;
    logic [MANT_W-1:0]   mant1;
    logic [SHIFT_W-1:0]  shamt1;
    logic                sign1, sign2;
    logic [MAG_W-1:0]    mag2;
    logic [MANT_W:0]     lin;
    logic [MAG_W-1:0]    mag_c;
`ifdef JT51_EXP_ROUND_EN
    logic [OUT_W-1:0]    rsum;
`endif

    jt51_exp2lin_rom #(.FRAC_W(FRAC_W), .MANT_W(MANT_W)) u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .addr  (bus.atten[FRAC_W-1:0]),
        .q     (mant1)
    );

    always_comb begin
        lin = (int'(shamt1) > MANT_W) ? '0 : ({1'b1, mant1} >> shamt1);
`ifdef JT51_EXP_ROUND_EN
        rsum  = OUT_W'(lin >> LSB) + OUT_W'(lin[LSB-1]);
        mag_c = rsum[MAG_W] ? '1 : rsum[MAG_W-1:0];
`else
        mag_c = MAG_W'(lin >> LSB);
`endif
    end

    // armed stays low on the first edge after reset so the release edge never captures a sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b0;
            vld_pipe <= '0;
            shamt1   <= '0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            mag2     <= '0;
            bus.dout <= '0;
        end else begin
            armed <= 1'b1;
            if (cen) begin
                vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid & armed};
                shamt1   <= bus.atten[SHIFT_W+FRAC_W-1 -: SHIFT_W];
                sign1    <= bus.sign;
                sign2    <= sign1;
                mag2     <= mag_c;
                bus.dout <= sign2 ? -{1'b0, mag2} : {1'b0, mag2};
            end
        end
    end

    assign bus.out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_jt51_exp2lin.sv
// Scoreboard bench for jt51_exp2lin: directed vectors, table sweep, cen stall and reset flush.
module tb_jt51_exp2lin;
    import jt51_exp_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic cen   = 1'b0;

    jt51_exp2lin_if #(.SHIFT_W(5), .FRAC_W(8), .OUT_W(14)) bus();

    jt51_exp2lin #(.FRAC_W(8), .MANT_W(16), .SHIFT_W(5), .OUT_W(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    val;
        int    due;
        string name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cen_cnt  = 0;

`ifdef JT51_EXP_ROUND_EN
    localparam int E000 = 8170;
    localparam int E07F = 5793;
`else
    localparam int E000 = 8169;
    localparam int E07F = 5792;
`endif

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int tbl_f(input int i);
        real x;
        x = (2.0 ** (1.0 - real'(i + 1) / 256.0) - 1.0) * 65536.0;
        return $rtoi(x + 0.5);
    endfunction

    // Expected output at int=0 from a mantissa value
    function automatic int mag_f(input int m);
        int l, mag;
        l   = 65536 | m;
        mag = l >> 4;
`ifdef JT51_EXP_ROUND_EN
        mag = mag + ((l >> 3) & 1);
        if (mag > 8191) mag = 8191;
`endif
        return mag;
    endfunction

    // Monitor: consumes one sample per cen-high edge with out_valid set
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && cen) begin
            cen_cnt++;
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got dout=%0d with empty scoreboard", $signed(bus.dout));
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_val"}, int'($signed(bus.dout)), e.val);
                    check({e.name, "_lat"}, cen_cnt, e.due);
                end
            end
        end
    end

    // Called just after a negedge with cen=1; returns at the following negedge
    task automatic send(input int a, input bit s, input int e, input string nm);
        bus.in_valid = 1'b1;
        bus.atten    = 13'(a);
        bus.sign     = s;
        sb.push_back('{e, cen_cnt + 3, nm});
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.atten    = '0;
        bus.sign     = 1'b0;
        cen          = 1'b1;
        rst_n        = 1'b0;
        idle(3);
        check("rst_dout", int'($signed(bus.dout)), 0);
        check("rst_ov", int'(bus.out_valid), 0);
        rst_n = 1'b1;
        idle(2);

        // Single samples with idle gaps (one-cycle out_valid pulse)
        send(13'h000, 1'b0, E000, "a000");
        idle(4);
        send(13'h0FF, 1'b0, 4096, "a0ff");
        idle(4);
        send(13'h1FF, 1'b0, 2048, "a1ff");
        send(13'h0FF, 1'b1, -4096, "a0ff_neg");
        send(13'h1100, 1'b0, 0, "int17_pos");
        send(13'h1100, 1'b1, 0, "int17_neg");
        send(13'h07F, 1'b0, E07F, "a07f");
        idle(5);

        // Back-to-back stream
        send(13'h000, 1'b0, E000, "s0");
        send(13'h0FF, 1'b0, 4096, "s1");
        send(13'h1FF, 1'b0, 2048, "s2");
        idle(4);

        // Table sweep at int=0, S1 mantissa checked directly
        for (int i = 0; i < 256; i++) begin
            send(i, 1'b0, mag_f(tbl_f(i)), "sweep");
            check("tbl_formula", int'(dut.u_rom.q), tbl_f(i));
            if (i == 0)   check("tbl_first", int'(dut.u_rom.q), 16'hFE9E);
            if (i == 127) check("tbl_mid",   int'(dut.u_rom.q), 16'h6A0A);
            if (i == 255) check("tbl_last",  int'(dut.u_rom.q), 16'h0000);
        end
        idle(4);

        // cen stall with first output presented and two samples in flight
        send(13'h000, 1'b0, E000, "st0");
        send(13'h0FF, 1'b0, 4096, "st1");
        send(13'h1FF, 1'b0, 2048, "st2");
        cen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_dout", int'($signed(bus.dout)), E000);
            check("stall_ov", int'(bus.out_valid), 1);
        end
        cen = 1'b1;
        idle(5);

        // Asynchronous reset with output valid and two samples in flight
        send(13'h000, 1'b0, E000, "r0");
        send(13'h0FF, 1'b0, 4096, "r1");
        send(13'h1FF, 1'b0, 2048, "r2");
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dout", int'($signed(bus.dout)), 0);
        check("arst_ov", int'(bus.out_valid), 0);
        sb.delete();
        idle(2);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_ov", int'(bus.out_valid), 0);
        end

        check("drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
